// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter: core port A, DMA/debug port B,
// the shared memory port and the busy flag.
interface dmem_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_ack;
   logic [31:0] a_rdata;
   logic        a_err;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_ack;
   logic [31:0] b_rdata;
   logic        b_err;

   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata, a_err,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata, b_err,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata, a_err,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata, b_err,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-cycle data memory between a core port (A)
// and a DMA/debug port (B); each transaction runs IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
   parameter int DEPTH = 128
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        winner;
   logic        in_range;

   assign in_range = ((addr_q >> AW) == 32'd0);

   // A lone requester wins; on a tie the port not served last wins.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      winner       = PORT_A;

      case (state_q)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               if (bus.a_req && bus.b_req) begin
                  winner = ~last_owner_q;
               end else begin
                  winner = bus.b_req ? PORT_B : PORT_A;
               end
               state_d      = ACCESS;
               owner_d      = winner;
               last_owner_d = winner;
               we_d         = (winner == PORT_B) ? bus.b_we    : bus.a_we;
               addr_d       = (winner == PORT_B) ? bus.b_addr  : bus.a_addr;
               wdata_d      = (winner == PORT_B) ? bus.b_wdata : bus.a_wdata;
            end
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = (!we_q && in_range) ? bus.mem_rdata : 32'd0;
            err_d   = !in_range;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= PORT_A;
         last_owner_q <= PORT_B;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // Outputs are forced quiet while rst is high so nothing leaks out during reset.
   always_comb begin
      bus.mem_addr  = 32'd0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 32'd0;
      bus.a_ack     = 1'b0;
      bus.a_rdata   = 32'd0;
      bus.a_err     = 1'b0;
      bus.b_ack     = 1'b0;
      bus.b_rdata   = 32'd0;
      bus.b_err     = 1'b0;
      bus.busy      = 1'b0;

      if (!rst) begin
         bus.busy = (state_q != IDLE);
         case (state_q)
            ACCESS: begin
               bus.mem_addr  = {{(32-AW){1'b0}}, addr_q[AW-1:0]};
               bus.mem_wdata = wdata_q;
               bus.mem_we    = we_q && in_range;
            end
            RESP: begin
               if (owner_q == PORT_B) begin
                  bus.b_ack   = 1'b1;
                  bus.b_rdata = rdata_q;
                  bus.b_err   = err_q;
               end else begin
                  bus.a_ack   = 1'b1;
                  bus.a_rdata = rdata_q;
                  bus.a_err   = err_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
